// File: rtl/bor_bist_pkg.sv
// -----------------------------------------------------------------------------
// bor_bist_pkg
// Shared definitions for the bitwise_or built-in self-test controller:
//   - state_e      : controller states (IDLE, DRIVE, SAMPLE, DONE)
//   - vec_width()  : width of the exhaustive vector index (two operands)
//   - err_width()  : width of the error counter; one bit wider than the
//                    vector index so a run where every vector fails fits.
// -----------------------------------------------------------------------------
package bor_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Vector index covers both operands back to back.
    function automatic int vec_width(input int width);
        return 2 * width;
    endfunction

    // 2^(2W) failures need 2W+1 bits, so the counter never wraps.
    function automatic int err_width(input int width);
        return (2 * width) + 1;
    endfunction

endpackage

// File: rtl/bor_bist.sv
// -----------------------------------------------------------------------------
// bor_bist
// Exhaustive self-test controller for a bitwise_or unit. Sweeps every operand
// pair, holds each pair SETTLE cycles, then compares the unit's result with
// in1 | in2. Counts mismatches, captures the first failing vector and reports
// a pass/fail verdict once the sweep completes.
//
// Ports:
//   clk        in   clock, all state updates on rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a run (honoured only in IDLE or DONE)
//   dut_in1    out  operand A to the unit (registered)
//   dut_in2    out  operand B to the unit (registered)
//   dut_out    in   result from the unit
//   busy       out  run in progress (DRIVE/SAMPLE)
//   done       out  run complete
//   pass       out  verdict, meaningful while done=1
//   err_count  out  mismatching vectors in current/last run
//   fail_in1/fail_in2/fail_out out  first mismatching vector and its result
// -----------------------------------------------------------------------------
module bor_bist
    import bor_bist_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     dut_in1,
    output logic [WIDTH-1:0]     dut_in2,
    input  logic [WIDTH-1:0]     dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic [WIDTH-1:0]     fail_in1,
    output logic [WIDTH-1:0]     fail_in2,
    output logic [WIDTH-1:0]     fail_out
);

    localparam int VW = vec_width(WIDTH);
    localparam int EW = err_width(WIDTH);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [VW-1:0]    VEC_ZERO   = {VW{1'b0}};
    localparam logic [VW-1:0]    VEC_ONE    = VW'(1);
    localparam logic [VW-1:0]    VEC_LAST   = {VW{1'b1}};
    localparam logic [EW-1:0]    ERR_ZERO   = {EW{1'b0}};
    localparam logic [EW-1:0]    ERR_ONE    = EW'(1);
    localparam logic [CW-1:0]    CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]    CNT_LAST   = CW'(SETTLE - 1);
    localparam logic [WIDTH-1:0] OPND_ZERO  = {WIDTH{1'b0}};

    state_e           state_r;
    state_e           state_s;
    logic [VW-1:0]    vec_r;
    logic [CW-1:0]    settle_cnt_r;
    logic [EW-1:0]    err_count_r;
    logic [WIDTH-1:0] fail_in1_r;
    logic [WIDTH-1:0] fail_in2_r;
    logic [WIDTH-1:0] fail_out_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;

    logic [WIDTH-1:0] opnd_a_s;
    logic [WIDTH-1:0] opnd_b_s;
    logic [WIDTH-1:0] expected_s;
    logic             mismatch_s;
    logic             settle_last_s;
    logic             vec_last_s;
    logic             launch_s;

    // Operands are slices of the vector register, so the unit sees flop outputs.
    assign opnd_a_s      = vec_r[VW-1:WIDTH];
    assign opnd_b_s      = vec_r[WIDTH-1:0];
    assign expected_s    = opnd_a_s | opnd_b_s;
    assign mismatch_s    = (dut_out != expected_s);
    assign settle_last_s = (settle_cnt_r == CNT_LAST);
    assign vec_last_s    = (vec_r == VEC_LAST);
    assign launch_s      = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_DRIVE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (settle_last_s) begin
                    state_s = ST_SAMPLE;
                end else begin
                    state_s = ST_DRIVE;
                end
            end
            ST_SAMPLE: begin
                if (vec_last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRIVE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s = ST_DRIVE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: vector sweep, settle timer, error bookkeeping and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_r        <= VEC_ZERO;
            settle_cnt_r <= CNT_ZERO;
            err_count_r  <= ERR_ZERO;
            fail_in1_r   <= OPND_ZERO;
            fail_in2_r   <= OPND_ZERO;
            fail_out_r   <= OPND_ZERO;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
        end else begin
            // Flags follow the state being entered so they line up with it.
            busy_r <= (state_s == ST_DRIVE) || (state_s == ST_SAMPLE);
            done_r <= (state_s == ST_DONE);

            if (launch_s) begin
                vec_r        <= VEC_ZERO;
                settle_cnt_r <= CNT_ZERO;
                err_count_r  <= ERR_ZERO;
                fail_in1_r   <= OPND_ZERO;
                fail_in2_r   <= OPND_ZERO;
                fail_out_r   <= OPND_ZERO;
                pass_r       <= 1'b0;
            end else begin
                case (state_r)
                    ST_DRIVE: begin
                        if (settle_last_s) begin
                            settle_cnt_r <= CNT_ZERO;
                        end else begin
                            settle_cnt_r <= settle_cnt_r + CNT_ONE;
                        end
                    end
                    ST_SAMPLE: begin
                        if (mismatch_s) begin
                            err_count_r <= err_count_r + ERR_ONE;
                            // Only the first failure of the run is kept.
                            if (err_count_r == ERR_ZERO) begin
                                fail_in1_r <= opnd_a_s;
                                fail_in2_r <= opnd_b_s;
                                fail_out_r <= dut_out;
                            end
                        end
                        if (vec_last_s) begin
                            // Verdict includes the final vector's own result.
                            pass_r <= (err_count_r == ERR_ZERO) && !mismatch_s;
                        end else begin
                            vec_r <= vec_r + VEC_ONE;
                        end
                    end
                    default: begin
                        vec_r <= vec_r;
                    end
                endcase
            end
        end
    end

    assign dut_in1   = opnd_a_s;
    assign dut_in2   = opnd_b_s;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_count_r;
    assign fail_in1  = fail_in1_r;
    assign fail_in2  = fail_in2_r;
    assign fail_out  = fail_out_r;

endmodule

// File: tb/tb_bor_bist.sv
// -----------------------------------------------------------------------------
// tb_bor_bist
// Two controllers: u_bist_a (SETTLE=1, combinational OR model) and
// u_bist_b (SETTLE=3, three-stage registered OR model). A fault switch forces
// result bit 0 low. Run records carry the expected verdict; each is queued
// when its start pulse is driven and compared when done rises.
// -----------------------------------------------------------------------------
module tb_bor_bist;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start_a = 1'b0;
    logic           start_b = 1'b0;
    logic           fault = 1'b0;
    logic           sel_b = 1'b0;

    logic [W-1:0]   in1_a, in2_a, out_a, f1_a, f2_a, fo_a;
    logic [W-1:0]   in1_b, in2_b, out_b, f1_b, f2_b, fo_b;
    logic           busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [2*W:0]   err_a, err_b;
    logic [W-1:0]   p0, p1, p2;
    logic [W-1:0]   fault_mask;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign fault_mask = fault ? 4'b1110 : 4'b1111;
    assign out_a = (in1_a | in2_a) & fault_mask;

    // Three-stage registered model for the latency test.
    always_ff @(posedge clk) begin
        p0 <= (in1_b | in2_b) & fault_mask;
        p1 <= p0;
        p2 <= p1;
    end
    assign out_b = p2;

    bor_bist #(.WIDTH(W), .SETTLE(1)) u_bist_a (
        .clk(clk), .rst(rst), .start(start_a),
        .dut_in1(in1_a), .dut_in2(in2_a), .dut_out(out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_in1(f1_a), .fail_in2(f2_a), .fail_out(fo_a)
    );

    bor_bist #(.WIDTH(W), .SETTLE(3)) u_bist_b (
        .clk(clk), .rst(rst), .start(start_b),
        .dut_in1(in1_b), .dut_in2(in2_b), .dut_out(out_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_in1(f1_b), .fail_in2(f2_b), .fail_out(fo_b)
    );

    // Selected controller's outputs.
    logic [W-1:0] m_in1, m_in2, m_f1, m_f2, m_fo;
    logic         m_busy, m_done, m_pass;
    logic [2*W:0] m_err;
    assign m_in1  = sel_b ? in1_b  : in1_a;
    assign m_in2  = sel_b ? in2_b  : in2_a;
    assign m_busy = sel_b ? busy_b : busy_a;
    assign m_done = sel_b ? done_b : done_a;
    assign m_pass = sel_b ? pass_b : pass_a;
    assign m_err  = sel_b ? err_b  : err_a;
    assign m_f1   = sel_b ? f1_b   : f1_a;
    assign m_f2   = sel_b ? f2_b   : f2_a;
    assign m_fo   = sel_b ? fo_b   : fo_a;

    typedef struct {
        bit           use_b;
        bit           fault_on;
        bit           mid_start;
        int           exp_done_cyc;
        int           exp_err;
        bit           exp_pass;
        logic [W-1:0] exp_f1;
        logic [W-1:0] exp_f2;
        logic [W-1:0] exp_fo;
    } run_t;

    run_t runs[5];
    run_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_one(input run_t r, input int idx);
        int           cyc;
        int           vec_err;
        int           settle;
        logic [7:0]   v_exp;
        run_t         e;
        sel_b  = r.use_b;
        fault  = r.fault_on;
        settle = r.use_b ? 3 : 1;
        @(negedge clk);
        if (r.use_b) start_b = 1'b1;
        else         start_a = 1'b1;
        sb_q.push_back(r);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        cyc = 1;
        vec_err = 0;
        chk($sformatf("run%0d_busy_c1", idx), {31'd0, m_busy}, 32'd1);
        chk($sformatf("run%0d_vec0", idx), {24'd0, m_in1, m_in2}, 32'd0);
        while (!m_done && cyc < 3000) begin
            v_exp = 8'((cyc - 1) / (settle + 1));
            if ({m_in1, m_in2} !== v_exp || m_busy !== 1'b1) vec_err++;
            if (r.mid_start && cyc == 200) begin
                if (r.use_b) start_b = 1'b1;
                else         start_a = 1'b1;
            end
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            cyc++;
        end
        e = sb_q.pop_front();
        chk($sformatf("run%0d_done_seen", idx), {31'd0, m_done}, 32'd1);
        chk($sformatf("run%0d_done_cycle", idx), cyc, e.exp_done_cyc);
        chk($sformatf("run%0d_busy_at_done", idx), {31'd0, m_busy}, 32'd0);
        chk($sformatf("run%0d_vec_seq_errs", idx), vec_err, 32'd0);
        chk($sformatf("run%0d_err_count", idx), {23'd0, m_err}, e.exp_err);
        chk($sformatf("run%0d_pass", idx), {31'd0, m_pass}, {31'd0, e.exp_pass});
        chk($sformatf("run%0d_fail_in1", idx), {28'd0, m_f1}, {28'd0, e.exp_f1});
        chk($sformatf("run%0d_fail_in2", idx), {28'd0, m_f2}, {28'd0, e.exp_f2});
        chk($sformatf("run%0d_fail_out", idx), {28'd0, m_fo}, {28'd0, e.exp_fo});
        repeat (3) @(negedge clk);
        chk($sformatf("run%0d_done_hold", idx), {31'd0, m_done}, 32'd1);
        chk($sformatf("run%0d_pass_hold", idx), {31'd0, m_pass}, {31'd0, e.exp_pass});
    endtask

    initial begin
        //        use_b fault mid  done  err  pass f1     f2     fo
        runs[0] = '{1'b0, 1'b0, 1'b0, 513,  0,   1'b1, 4'h0, 4'h0, 4'h0};
        runs[1] = '{1'b0, 1'b1, 1'b0, 513,  192, 1'b0, 4'h0, 4'h1, 4'h0};
        runs[2] = '{1'b0, 1'b0, 1'b1, 513,  0,   1'b1, 4'h0, 4'h0, 4'h0};
        runs[3] = '{1'b1, 1'b0, 1'b0, 1025, 0,   1'b1, 4'h0, 4'h0, 4'h0};
        runs[4] = '{1'b1, 1'b1, 1'b0, 1025, 192, 1'b0, 4'h0, 4'h1, 4'h0};

        // Reset held two cycles with start asserted: everything stays cleared.
        rst = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_pass", {31'd0, pass_a}, 32'd0);
        chk("rst_err", {23'd0, err_a}, 32'd0);
        chk("rst_in", {24'd0, in1_a, in2_a}, 32'd0);
        chk("rst_fail", {20'd0, f1_a, f2_a, fo_a}, 32'd0);
        chk("rst_b_busy_done", {30'd0, busy_b, done_b}, 32'd0);
        start_a = 1'b0;
        start_b = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle_busy", {31'd0, busy_a}, 32'd0);
        chk("post_rst_idle_done", {31'd0, done_a}, 32'd0);

        // Reset during a faulty run at vector 100.
        sel_b = 1'b0;
        fault = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (200) @(negedge clk);
        chk("pre_rst_vec100", {24'd0, in1_a, in2_a}, 32'd100);
        chk("pre_rst_fail_in2", {28'd0, f2_a}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_done_pass", {30'd0, done_a, pass_a}, 32'd0);
        chk("midrst_err", {23'd0, err_a}, 32'd0);
        chk("midrst_in", {24'd0, in1_a, in2_a}, 32'd0);
        chk("midrst_fail", {20'd0, f1_a, f2_a, fo_a}, 32'd0);
        @(negedge clk);
        chk("midrst_stays_idle", {31'd0, busy_a}, 32'd0);

        // Table of runs; runs after the first on each controller start from DONE.
        for (int i = 0; i < 5; i++) begin
            run_one(runs[i], i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
